axi_lite_reg_bank: RTL



---
 rtl/axi_lite_reg_bank_pkg.sv | 66 ++++++
 rtl/axi_lite_reg_bank_hold.sv | 44 ++++
 rtl/axi_lite_reg_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, default channel
// structs and the register-index width helper.
package axi_lite_reg_bank_pkg;

  localparam int unsigned AxiLiteAddrWidth = 32;
  localparam int unsigned AxiLiteDataWidth = 32;
  localparam int unsigned AxiLiteStrbWidth = AxiLiteDataWidth / 8;

  typedef logic [1:0] axi_resp_code_t;

  localparam axi_resp_code_t RESP_OKAY   = 2'b00;
  localparam axi_resp_code_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_code_t RESP_SLVERR = 2'b10;
  localparam axi_resp_code_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AxiLiteAddrWidth-1:0] addr;
    logic [2:0]                  prot;
  } axi_lite_aw_t;

  typedef struct packed {
    logic [AxiLiteDataWidth-1:0] data;
    logic [AxiLiteStrbWidth-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    axi_resp_code_t resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [AxiLiteAddrWidth-1:0] addr;
    logic [2:0]                  prot;
  } axi_lite_ar_t;

  typedef struct packed {
    logic [AxiLiteDataWidth-1:0] data;
    axi_resp_code_t              resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_aw_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ar_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

  // Index width never collapses to zero, even for a single register.
  function automatic int unsigned reg_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_hold.sv
// One-entry holding register: captures a payload that arrived without its
// partner channel and releases it when the write commits.
module axi_lite_reg_bank_hold #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  input  T     data_i,
  output logic full_o,
  output T     data_o
);

  logic full_q, full_d;
  T     data_q, data_d;

  // Clear has priority: a commit always drains the entry.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Entry state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NoRegs software-visible registers with parallel
// hardware load/observe ports and native SLVERR/DECERR responses.
module axi_lite_reg_bank
  import axi_lite_reg_bank_pkg::*;
#(
  parameter int unsigned                           NoRegs       = 8,
  parameter int unsigned                           AxiAddrWidth = 32,
  parameter int unsigned                           AxiDataWidth = 32,
  parameter logic [NoRegs-1:0][AxiDataWidth-1:0]   RegRstVal    = '0,
  parameter logic [NoRegs-1:0]                     ReadOnly     = '0,
  parameter type                                   axi_req_t    = axi_lite_req_t,
  parameter type                                   axi_resp_t   = axi_lite_resp_t,
  parameter int unsigned                           IdxWidth     = reg_idx_width(NoRegs)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  axi_req_t                               slv_req_i,
  output axi_resp_t                              slv_resp_o,
  input  logic [NoRegs-1:0][AxiDataWidth-1:0]    reg_d_i,
  input  logic [NoRegs-1:0]                      reg_load_i,
  output logic [NoRegs-1:0][AxiDataWidth-1:0]    reg_q_o,
  output logic [NoRegs-1:0]                      wr_pulse_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned Offset    = $clog2(StrbWidth);
  localparam int unsigned WBufWidth = AxiDataWidth + StrbWidth;
  localparam logic [AxiAddrWidth-1:0] AddrLimit = AxiAddrWidth'(NoRegs * StrbWidth);

  // Elaboration-time parameter sanity.
  if (NoRegs < 1) begin : g_err_noregs
    $error("axi_lite_reg_bank: NoRegs must be at least 1");
  end
  if ((AxiDataWidth != 32) && (AxiDataWidth != 64)) begin : g_err_width
    $error("axi_lite_reg_bank: AxiDataWidth must be 32 or 64");
  end

  // Register state
  logic [NoRegs-1:0][AxiDataWidth-1:0] reg_q, reg_d;
  logic [NoRegs-1:0]                   wr_pulse_q, wr_pulse_d;
  logic                                b_valid_q, b_valid_d;
  axi_resp_code_t                      b_resp_q, b_resp_d;
  logic                                r_valid_q, r_valid_d;
  logic [AxiDataWidth-1:0]             r_data_q, r_data_d;
  axi_resp_code_t                      r_resp_q, r_resp_d;

  // Write path
  logic                    aw_full, w_full;
  logic                    aw_fire, w_fire, commit;
  logic [AxiAddrWidth-1:0] aw_buf_addr, wr_addr;
  logic [WBufWidth-1:0]    w_buf, w_in, w_cur;
  logic [AxiDataWidth-1:0] wr_data;
  logic [StrbWidth-1:0]    wr_strb;
  logic [IdxWidth-1:0]     wr_idx;
  logic                    wr_decerr;
  axi_resp_code_t          wr_resp;
  logic                    wr_ok;

  // Read path
  logic                    ar_ready, ar_fire;
  logic [IdxWidth-1:0]     rd_idx;
  logic                    rd_decerr;

  logic unused_bits;

  // Handshakes and commit: a write retires when both halves are present and
  // the B slot is free (or being freed this cycle).
  always_comb begin
    aw_fire = slv_req_i.aw_valid && !aw_full;
    w_fire  = slv_req_i.w_valid && !w_full;
    commit  = (aw_full || aw_fire) && (w_full || w_fire) &&
              (!b_valid_q || slv_req_i.b_ready);
  end

  axi_lite_reg_bank_hold #(
    .T(logic [AxiAddrWidth-1:0])
  ) u_aw_hold (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (aw_fire && !commit),
    .clear_i(commit),
    .data_i (slv_req_i.aw.addr),
    .full_o (aw_full),
    .data_o (aw_buf_addr)
  );

  assign w_in = {slv_req_i.w.data, slv_req_i.w.strb};

  axi_lite_reg_bank_hold #(
    .T(logic [WBufWidth-1:0])
  ) u_w_hold (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (w_fire && !commit),
    .clear_i(commit),
    .data_i (w_in),
    .full_o (w_full),
    .data_o (w_buf)
  );

  // Write decode: held payload wins over the live channel.
  always_comb begin
    wr_addr   = aw_full ? aw_buf_addr : slv_req_i.aw.addr;
    w_cur     = w_full ? w_buf : w_in;
    wr_data   = w_cur[WBufWidth-1 -: AxiDataWidth];
    wr_strb   = w_cur[StrbWidth-1:0];
    wr_idx    = wr_addr[Offset +: IdxWidth];
    wr_decerr = (wr_addr >= AddrLimit);
    if (wr_decerr) begin
      wr_resp = RESP_DECERR;
    end else if (ReadOnly[wr_idx]) begin
      wr_resp = RESP_SLVERR;
    end else begin
      wr_resp = RESP_OKAY;
    end
    wr_ok = commit && (wr_resp == RESP_OKAY);
  end

  // Read decode.
  always_comb begin
    ar_ready  = !r_valid_q || slv_req_i.r_ready;
    ar_fire   = slv_req_i.ar_valid && ar_ready;
    rd_idx    = slv_req_i.ar.addr[Offset +: IdxWidth];
    rd_decerr = (slv_req_i.ar.addr >= AddrLimit);
  end

  // Register next state: hardware load first, then strobed bus bytes override.
  always_comb begin
    reg_d      = reg_q;
    wr_pulse_d = '0;
    for (int unsigned k = 0; k < NoRegs; k++) begin
      if (reg_load_i[k]) begin
        reg_d[k] = reg_d_i[k];
      end
      if (wr_ok && (wr_idx == IdxWidth'(k))) begin
        wr_pulse_d[k] = 1'b1;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
          if (wr_strb[b]) begin
            reg_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // B and R channel next state; R samples the pre-update register contents.
  always_comb begin
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (commit) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_resp;
    end else if (slv_req_i.b_ready) begin
      b_valid_d = 1'b0;
    end
    if (ar_fire) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_decerr ? '0 : reg_q[rd_idx];
      r_resp_d  = rd_decerr ? RESP_DECERR : RESP_OKAY;
    end else if (slv_req_i.r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q      <= RegRstVal;
      wr_pulse_q <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      reg_q      <= reg_d;
      wr_pulse_q <= wr_pulse_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Response bundle.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = !aw_full;
    slv_resp_o.w_ready  = !w_full;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = r_valid_q;
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
  end

  assign reg_q_o     = reg_q;
  assign wr_pulse_o  = wr_pulse_q;
  assign unused_bits = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

`ifndef SYNTHESIS
  // Masters must hold valid and payload until the handshake.
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_req_i.aw_valid && !slv_resp_o.aw_ready) |=>
    (slv_req_i.aw_valid && $stable(slv_req_i.aw)))
    else $error("AW valid/payload changed before handshake");
  a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_req_i.w_valid && !slv_resp_o.w_ready) |=>
    (slv_req_i.w_valid && $stable(slv_req_i.w)))
    else $error("W valid/payload changed before handshake");
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_req_i.ar_valid && !slv_resp_o.ar_ready) |=>
    (slv_req_i.ar_valid && $stable(slv_req_i.ar)))
    else $error("AR valid/payload changed before handshake");
`endif

endmodule
